// File: rtl/mod_counter_sched_if.sv
// Bus between the requesters and the shared mod counter scheduler:
// request levels and start values in, grant, count and completion out.
interface mod_counter_sched_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] data;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic [W-1:0]       count;
  logic               wrap;
  logic [N_REQ-1:0]   done;

  modport master (output req, data, input gnt, busy, count, wrap, done);
  modport slave  (input req, data, output gnt, busy, count, wrap, done);
endinterface

// File: rtl/mod_counter_sched.sv
// Round-robin arbiter and controller that lends one loadable mod-MOD up
// counter to N_REQ requesters, one start-to-wrap run per grant.
module mod_counter_sched #(
  parameter int N_REQ = 4,
  parameter int MOD   = 47,
  parameter int W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_counter_sched_if.slave   bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    rr_ptr, owner, owner_inc, pick;
  logic [W-1:0]     count_q, start, start_clip;
  logic [N_REQ-1:0] gnt_q, done_q;
  logic             wrap_q;
  logic             found, abort, at_top;
  int               idx;

  // Rotating priority search starting at rr_ptr; first requester found wins.
  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign owner_inc  = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign start      = bus.data[owner*W +: W];
  assign start_clip = (int'(start) < MOD) ? start : '0;
  assign abort      = (state != IDLE) && !bus.req[owner];
  assign at_top     = (count_q == W'(MOD - 1));

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort takes precedence over load and wrap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = LOAD;
      LOAD:    state_nxt = abort ? IDLE : RUN;
      RUN:     if (abort || at_top) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.busy = (state != IDLE);
  end

  // Registered datapath: counter, grant, pulses and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      wrap_q  <= 1'b0;
      rr_ptr  <= '0;
      owner   <= '0;
    end else begin
      done_q <= '0;
      wrap_q <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            owner <= pick;
            gnt_q <= ONE << pick;
          end
        end
        LOAD: begin
          if (abort) begin
            gnt_q  <= '0;
            rr_ptr <= owner_inc;
          end else begin
            count_q <= start_clip;
          end
        end
        RUN: begin
          if (abort) begin
            gnt_q  <= '0;
            rr_ptr <= owner_inc;
          end else if (at_top) begin
            count_q <= '0;
            wrap_q  <= 1'b1;
            done_q  <= ONE << owner;
            gnt_q   <= '0;
            rr_ptr  <= owner_inc;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: gnt_q <= '0;
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_mod_counter_sched.sv
// Directed bench for mod_counter_sched: single runs, clipping, round-robin
// rotation, aborts in LOAD and RUN, and asynchronous reset mid-run.
module tb_mod_counter_sched;

  localparam int N_REQ = 4;
  localparam int MOD   = 47;
  localparam int W     = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  mod_counter_sched_if #(.N_REQ(N_REQ), .W(W)) bus ();

  mod_counter_sched #(.N_REQ(N_REQ), .MOD(MOD), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    bus.data[i*W +: W] = v;
  endtask

  task automatic check_idle(input string tag, input logic [W-1:0] cnt);
    check({tag, "_gnt"},  32'(bus.gnt),   32'h0);
    check({tag, "_busy"}, 32'(bus.busy),  32'h0);
    check({tag, "_cnt"},  32'(bus.count), 32'(cnt));
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.data = '0;
    tick(1);
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_gnt",   32'(bus.gnt),   32'h0);
    check("rst_done",  32'(bus.done),  32'h0);
    check("rst_wrap",  32'(bus.wrap),  32'h0);
    check("rst_busy",  32'(bus.busy),  32'h0);
    rst = 1'b0;

    // Requester 0, start 0: full 47-count run, done after E49.
    set_data(0, 8'd0);
    bus.req = 4'b0001;
    tick(1);
    check("t1_e1_gnt",  32'(bus.gnt),  32'h1);
    check("t1_e1_busy", 32'(bus.busy), 32'h1);
    tick(1);
    check("t1_e2_cnt",  32'(bus.count), 32'd0);
    for (int i = 1; i <= 46; i++) begin
      tick(1);
      check("t1_run_cnt", 32'(bus.count), 32'(i));
      check("t1_run_wrap", 32'(bus.wrap), 32'h0);
    end
    tick(1);
    check("t1_e49_wrap", 32'(bus.wrap), 32'h1);
    check("t1_e49_done", 32'(bus.done), 32'h1);
    check_idle("t1_e49", 8'd0);
    bus.req = '0;
    tick(1);
    check("t1_pulse_done", 32'(bus.done), 32'h0);
    check("t1_pulse_wrap", 32'(bus.wrap), 32'h0);

    // Requester 2, start 40: count 40 after E2, 46 after E8, done after E9.
    set_data(2, 8'd40);
    bus.req = 4'b0100;
    tick(1);
    check("t2_e1_gnt", 32'(bus.gnt), 32'h4);
    tick(1);
    check("t2_e2_cnt", 32'(bus.count), 32'd40);
    tick(6);
    check("t2_e8_cnt", 32'(bus.count), 32'd46);
    check("t2_e8_done", 32'(bus.done), 32'h0);
    tick(1);
    check("t2_e9_done", 32'(bus.done), 32'h4);
    check("t2_e9_wrap", 32'(bus.wrap), 32'h1);
    check_idle("t2_e9", 8'd0);
    bus.req = '0;

    // Fresh reset, all four requesting with start 45: grants 0,1,2,3,0 back to back.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_data(i, 8'd45);
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick(1);
      check("t3_gnt", 32'(bus.gnt), 32'(4'b0001 << (g % 4)));
      tick(1);
      check("t3_load", 32'(bus.count), 32'd45);
      tick(1);
      check("t3_top", 32'(bus.count), 32'd46);
      tick(1);
      check("t3_done", 32'(bus.done), 32'(4'b0001 << (g % 4)));
      check("t3_wrap", 32'(bus.wrap), 32'h1);
      check("t3_gnt_off", 32'(bus.gnt), 32'h0);
    end
    bus.req = '0;

    // Requester 1 with out-of-range start 60: clipped to 0, done after E1+48.
    set_data(1, 8'd60);
    bus.req = 4'b0010;
    tick(1);
    check("t4_e1_gnt", 32'(bus.gnt), 32'h2);
    tick(1);
    check("t4_clip_cnt", 32'(bus.count), 32'd0);
    tick(46);
    check("t4_e48_cnt", 32'(bus.count), 32'd46);
    check("t4_e48_done", 32'(bus.done), 32'h0);
    tick(1);
    check("t4_e49_done", 32'(bus.done), 32'h2);
    bus.req = '0;

    // Requester 0 start 10, aborted in RUN at count 20; then 1 beats 3.
    set_data(0, 8'd10);
    set_data(1, 8'd5);
    set_data(3, 8'd0);
    bus.req = 4'b0001;
    tick(1);
    check("t5_e1_gnt", 32'(bus.gnt), 32'h1);
    tick(11);
    check("t5_e12_cnt", 32'(bus.count), 32'd20);
    bus.req = 4'b1010;
    tick(1);
    check_idle("t5_abort", 8'd20);
    check("t5_abort_done", 32'(bus.done), 32'h0);
    check("t5_abort_wrap", 32'(bus.wrap), 32'h0);
    tick(1);
    check("t5_next_gnt", 32'(bus.gnt), 32'h2);

    // Abort in LOAD beats the load: count keeps 20.
    bus.req = 4'b1000;
    tick(1);
    check_idle("t5_load_abort", 8'd20);
    tick(1);
    check("t5_gnt3", 32'(bus.gnt), 32'h8);

    // Async reset mid-run at count 30.
    tick(31);
    check("t6_cnt30", 32'(bus.count), 32'd30);
    rst = 1'b1;
    #1;
    check_idle("t6_rst", 8'd0);
    check("t6_rst_done", 32'(bus.done), 32'h0);
    bus.req = 4'b1001;
    tick(1);
    check_idle("t6_rst_held", 8'd0);
    rst = 1'b0;
    tick(1);
    check("t6_rr0_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
